// File: rtl/display_fmt_if.sv
// Handshake and segment-image bundle between a value producer and display_fmt.
// The master drives the request; the slave (display_fmt) returns ready, image and update.
interface display_fmt_if;
   logic [31:0] value;
   logic        hex_mode;
   logic [8:0]  dp_mask;
   logic        value_valid;
   logic        ready;
   logic [71:0] display_bits;
   logic        update;

   modport master (
      output value, hex_mode, dp_mask, value_valid,
      input  ready, display_bits, update
   );

   modport slave (
      input  value, hex_mode, dp_mask, value_valid,
      output ready, display_bits, update
   );
endinterface

// File: rtl/display_fmt.sv
// Formats a 32-bit value as nine 7-segment digits (decimal via double-dabble, or hex).
// Optional build macro DISPLAY_FMT_LZB_EN enables leading-zero blanking.
module display_fmt (
   input  logic         clk,
   input  logic         rst_n,
   display_fmt_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CONVERT, ENCODE} state_e;

   localparam logic [31:0] MAX_DEC = 32'd999_999_999;

`ifdef DISPLAY_FMT_LZB_EN
   localparam bit LZB_EN = 1'b1;
`else
   localparam bit LZB_EN = 1'b0;
`endif

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 7'h3F;
         4'h1: seg7 = 7'h06;
         4'h2: seg7 = 7'h5B;
         4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;
         4'h5: seg7 = 7'h6D;
         4'h6: seg7 = 7'h7D;
         4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;
         4'h9: seg7 = 7'h6F;
         4'hA: seg7 = 7'h77;
         4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;
         4'hD: seg7 = 7'h5E;
         4'hE: seg7 = 7'h79;
         default: seg7 = 7'h71;
      endcase
   endfunction

   state_e      state_q, state_d;
   logic [31:0] value_q, value_d;
   logic        hex_q, hex_d;
   logic [8:0]  dp_q, dp_d;
   logic [35:0] bcd_q, bcd_d;
   logic [31:0] shift_q, shift_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [71:0] display_bits_q, display_bits_d;
   logic        update_q, update_d;

   logic [35:0] bcd_adj;
   logic [71:0] image;

   // Segment image from the captured registers; only latched in ENCODE.
   always_comb begin
      logic [35:0] src;
      logic        overflow;
      logic        seen;
      logic [3:0]  nib;
      logic [6:0]  seg;
      image    = '0;
      src      = hex_q ? {4'h0, value_q} : bcd_q;
      overflow = !hex_q && (value_q > MAX_DEC);
      seen     = 1'b0;
      nib      = '0;
      seg      = '0;
      for (int i = 8; i >= 0; i--) begin
         nib = src[4*i +: 4];
         if (nib != 4'h0) seen = 1'b1;
         if (overflow)
            seg = 7'h40;
         else if ((hex_q && i == 8) || (LZB_EN && !seen && i != 0))
            seg = 7'h00;
         else
            seg = seg7(nib);
         image[8*i +: 8] = {dp_q[i], seg};
      end
   end

   always_comb begin
      for (int j = 0; j < 9; j++) begin
         bcd_adj[4*j +: 4] = (bcd_q[4*j +: 4] >= 4'd5) ? bcd_q[4*j +: 4] + 4'd3
                                                          : bcd_q[4*j +: 4];
      end
   end

   // NOTE: every signal gets its hold value first, so no path can infer a latch.
   always_comb begin
      state_d        = state_q;
      value_d        = value_q;
      hex_d          = hex_q;
      dp_d           = dp_q;
      bcd_d          = bcd_q;
      shift_d        = shift_q;
      cnt_d          = cnt_q;
      display_bits_d = display_bits_q;
      update_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.value_valid) begin
               value_d = bus.value;
               hex_d   = bus.hex_mode;
               dp_d    = bus.dp_mask;
               bcd_d   = '0;
               shift_d = bus.value;
               cnt_d   = '0;
               state_d = (!bus.hex_mode && bus.value <= MAX_DEC) ? CONVERT : ENCODE;
            end
         end
         CONVERT: begin
            {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = ENCODE;
         end
         ENCODE: begin
            display_bits_d = image;
            update_d       = 1'b1;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         value_q        <= '0;
         hex_q          <= 1'b0;
         dp_q           <= '0;
         bcd_q          <= '0;
         shift_q        <= '0;
         cnt_q          <= '0;
         display_bits_q <= '0;
         update_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         value_q        <= value_d;
         hex_q          <= hex_d;
         dp_q           <= dp_d;
         bcd_q          <= bcd_d;
         shift_q        <= shift_d;
         cnt_q          <= cnt_d;
         display_bits_q <= display_bits_d;
         update_q       <= update_d;
      end
   end

   assign bus.ready        = (state_q == IDLE);
   assign bus.display_bits = display_bits_q;
   assign bus.update       = update_q;

endmodule

// File: tb/tb_display_fmt.sv
// Self-checking bench for display_fmt: random values compared against an arithmetic model.
// Honours DISPLAY_FMT_LZB_EN in the model so the same bench covers both builds.
module tb_display_fmt;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

`ifdef DISPLAY_FMT_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   always #5 clk = ~clk;

   display_fmt_if bus ();

   display_fmt dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [6:0] ref_seg(input longint unsigned d);
      logic [6:0] tab [16];
      tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return tab[d[3:0]];
   endfunction

   // Expected image from plain division/shift arithmetic.
   function automatic logic [71:0] model(input logic [31:0] v, input logic h, input logic [8:0] dp);
      logic [71:0]     r;
      longint unsigned vv, p, q;
      logic [6:0]      s;
      r  = '0;
      vv = longint'(v);
      p  = 1;
      for (int i = 0; i < 9; i++) begin
         if (h) begin
            q = vv >> (4 * i);
            if (i == 8) s = 7'h00;
            else if (LZB && i > 0 && q == 0) s = 7'h00;
            else s = ref_seg(q % 16);
         end else if (vv > 64'd999_999_999) begin
            s = 7'h40;
         end else begin
            q = vv / p;
            if (LZB && i > 0 && q == 0) s = 7'h00;
            else s = ref_seg(q % 10);
         end
         r[8*i +: 8] = {dp[i], s};
         p = p * 10;
      end
      return r;
   endfunction

   // Drives one request and waits (bounded) for the update pulse; lat = -1 on timeout.
   task automatic send_and_wait(input logic [31:0] v, input logic h, input logic [8:0] dp,
                                output int lat, output logic [71:0] bits, output logic rdy);
      bus.value       = v;
      bus.hex_mode    = h;
      bus.dp_mask     = dp;
      bus.value_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.value_valid = 1'b0;
      lat  = -1;
      bits = '0;
      rdy  = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (bus.update === 1'b1) begin
            lat  = k;
            bits = bus.display_bits;
            rdy  = bus.ready;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bus.value       = '0;
      bus.hex_mode    = 1'b0;
      bus.dp_mask     = '0;
      bus.value_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.display_bits !== 72'h0) begin
         errors++; $display("FAIL reset_bits: got %h expected %h", bus.display_bits, 72'h0);
      end
      checks++;
      if (bus.ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready);
      end
      checks++;
      if (bus.update !== 1'b0) begin
         errors++; $display("FAIL reset_update: got %b expected 0", bus.update);
      end
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.update !== 1'b0 || bus.display_bits !== 72'h0 || bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_state: got upd=%b bits=%h rdy=%b expected 0/0/1",
                  bus.update, bus.display_bits, bus.ready);
      end
   endtask

   task automatic run_one(input string name, input logic [31:0] v, input logic h,
                          input logic [8:0] dp, input int exp_lat);
      int          lat;
      logic [71:0] bits, exp_bits;
      logic        rdy;
      exp_bits = model(v, h, dp);
      send_and_wait(v, h, dp, lat, bits, rdy);
      checks++;
      if (lat !== exp_lat) begin
         errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
      end
      checks++;
      if (bits !== exp_bits) begin
         errors++; $display("FAIL %s_bits: got %h expected %h (v=%h hex=%b)", name, bits, exp_bits, v, h);
      end
      checks++;
      if (rdy !== 1'b1) begin
         errors++; $display("FAIL %s_ready_at_update: got %b expected 1", name, rdy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.update !== 1'b0) begin
         errors++; $display("FAIL %s_update_width: got %b expected 0", name, bus.update);
      end
   endtask

   task automatic test_decimal();
      int          lat;
      logic [71:0] bits;
      logic        rdy;
      logic [71:0] exp_1234;
      exp_1234 = LZB ? 72'h00_00_00_00_00_06_5B_4F_66 : 72'h3F_3F_3F_3F_3F_06_5B_4F_66;
      send_and_wait(32'd1234, 1'b0, 9'h0, lat, bits, rdy);
      checks++;
      if (lat !== 33 || bits !== exp_1234) begin
         errors++; $display("FAIL dec_1234: got lat=%0d bits=%h expected lat=33 bits=%h", lat, bits, exp_1234);
      end
      @(posedge clk);
      #1;
      for (int n = 0; n < 6; n++)
         run_one("dec_rand", $urandom_range(999_999_999, 0), 1'b0, 9'($urandom), 33);
   endtask

   task automatic test_hex();
      int          lat;
      logic [71:0] bits;
      logic        rdy;
      send_and_wait(32'hDEADBEEF, 1'b1, 9'h001, lat, bits, rdy);
      checks++;
      if (lat !== 1 || bits !== 72'h00_5E_79_77_5E_7C_79_79_F1) begin
         errors++; $display("FAIL hex_deadbeef: got lat=%0d bits=%h expected lat=1 bits=%h",
                            lat, bits, 72'h00_5E_79_77_5E_7C_79_79_F1);
      end
      @(posedge clk);
      #1;
      run_one("hex_small", 32'h0000_00A0, 1'b1, 9'h1FF, 1);
      for (int n = 0; n < 5; n++)
         run_one("hex_rand", $urandom >> $urandom_range(28, 0), 1'b1, 9'($urandom), 1);
   endtask

   task automatic test_boundaries();
      run_one("ovf_1e9", 32'd1_000_000_000, 1'b0, 9'h0, 1);
      run_one("ovf_max", 32'hFFFF_FFFF, 1'b0, 9'($urandom), 1);
      run_one("dec_max", 32'd999_999_999, 1'b0, 9'h100, 33);
      run_one("dec_zero", 32'd0, 1'b0, 9'h0, 33);
      run_one("hex_zero", 32'd0, 1'b1, 9'h0, 1);
   endtask

   task automatic test_ignore_during_convert();
      int          lat, early_ready, extra_updates;
      logic [71:0] bits;
      bus.value       = 32'd42;
      bus.hex_mode    = 1'b0;
      bus.dp_mask     = 9'h0;
      bus.value_valid = 1'b1;
      @(posedge clk);
      #1;
      lat = -1;
      bits = '0;
      early_ready = 0;
      for (int k = 1; k <= 60; k++) begin
         if (k <= 20) begin
            bus.value       = $urandom;
            bus.hex_mode    = 1'($urandom);
            bus.dp_mask     = 9'($urandom);
            bus.value_valid = 1'($urandom);
         end else begin
            bus.value_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         if (bus.update === 1'b1) begin
            lat  = k;
            bits = bus.display_bits;
            break;
         end
         if (bus.ready !== 1'b0) early_ready++;
      end
      bus.value_valid = 1'b0;
      checks++;
      if (early_ready !== 0) begin
         errors++; $display("FAIL busy_ready: got %0d ready cycles expected 0", early_ready);
      end
      checks++;
      if (lat !== 33 || bits !== model(32'd42, 1'b0, 9'h0)) begin
         errors++; $display("FAIL hold_42: got lat=%0d bits=%h expected lat=33 bits=%h",
                            lat, bits, model(32'd42, 1'b0, 9'h0));
      end
      extra_updates = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.update === 1'b1) extra_updates++;
      end
      checks++;
      if (extra_updates !== 0) begin
         errors++; $display("FAIL no_queueing: got %0d updates expected 0", extra_updates);
      end
   endtask

   task automatic test_reset_mid();
      int          lat, stray;
      logic [71:0] bits;
      logic        rdy;
      bus.value       = 32'd123_456_789;
      bus.hex_mode    = 1'b0;
      bus.dp_mask     = 9'h0;
      bus.value_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.value_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.display_bits !== 72'h0 || bus.update !== 1'b0 || bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: got bits=%h upd=%b rdy=%b expected 0/0/1",
                  bus.display_bits, bus.update, bus.ready);
      end
      rst_n = 1'b1;
      stray = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.update === 1'b1) stray++;
      end
      checks++;
      if (stray !== 0) begin
         errors++; $display("FAIL reset_mid_no_update: got %0d updates expected 0", stray);
      end
      send_and_wait(32'h5, 1'b1, 9'h0, lat, bits, rdy);
      checks++;
      if (lat !== 1 || bits[7:0] !== 8'h6D || bits !== model(32'h5, 1'b1, 9'h0)) begin
         errors++; $display("FAIL post_reset_hex5: got lat=%0d bits=%h expected lat=1 bits=%h",
                            lat, bits, model(32'h5, 1'b1, 9'h0));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int          lat;
      logic [71:0] bits;
      logic        rdy;
      logic [31:0] v;
      logic [8:0]  dp;
      send_and_wait(32'd7, 1'b0, 9'h0, lat, bits, rdy);
      for (int n = 0; n < 4; n++) begin
         v  = (n % 2 == 0) ? $urandom : $urandom_range(999_999_999, 0);
         dp = 9'($urandom);
         send_and_wait(v, (n % 2 == 0), dp, lat, bits, rdy);
         checks++;
         if (lat !== ((n % 2 == 0) ? 1 : 33) || bits !== model(v, (n % 2 == 0), dp)) begin
            errors++; $display("FAIL back_to_back_%0d: got lat=%0d bits=%h expected bits=%h",
                               n, lat, bits, model(v, (n % 2 == 0), dp));
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_decimal();
      test_hex();
      test_boundaries();
      test_ignore_during_convert();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/display_fmt.md
# display_fmt

Upstream formatter for the serial LCD driver (`display`). It accepts a 32-bit value over a valid/ready handshake and converts it to nine 7-segment digits, either decimal via iterative double-dabble or hexadecimal. It then registers the 72-bit segment image that drives `display.display_bits`, and pulses `update` when a new image is in place.

## Interface
- No parameters; all widths are fixed by the 72-bit `display` input (9 digits × 8 bits).
- `clk`  in  1  system clock (CLK25MHZ domain).
- `rst_n`  in  1  synchronous, active-low reset.
- `value`  in  32  number to show; captured on accept.
- `hex_mode`  in  1  1 = hexadecimal, 0 = decimal; captured on accept.
- `dp_mask`  in  9  decimal-point enable per digit (bit i → digit i); captured on accept.
- `value_valid`  in  1  request strobe.
- `ready`  out  1  high only in IDLE; accept happens when `value_valid & ready`.
- `display_bits`  out  72  segment image; digit i occupies `[8i+7:8i]`, with digit 0 rightmost.
- `update`  out  1  one-cycle pulse when `display_bits` changes.

## Operation
- Byte layout: bit0=a … bit6=g, bit7=dp.
- Digit codes:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F
  - A:77, b:7C, C:39, d:5E, E:79, F:71
  - dash:40, blank:00
- dp: bit7 = the captured `dp_mask[i]` in every mode, including overflow and blanked digits.
- States: IDLE, CONVERT, ENCODE.
- IDLE → CONVERT on accept when decimal and `value` ≤ 999_999_999.
- IDLE → ENCODE on accept when in hex mode or in decimal overflow.
- CONVERT runs exactly 32 shift-add-3 iterations on a 36-bit BCD + 32-bit shift register, then goes to ENCODE.
- ENCODE registers `display_bits`, pulses `update`, and returns to IDLE.
- Decimal: digits 0–8 are the 9 BCD digits.
- Decimal overflow (`value` > 999_999_999): all nine digits show dash.
- Hex: digits 0–7 are nibbles 0–7 of `value`; digit 8 is always blank.
- Inputs are registered on accept. Later changes to `value`, `hex_mode` or `dp_mask` during conversion have no effect.
- `value_valid` while `ready`=0 is ignored; there is no queueing.
- `display_bits` holds its previous image until ENCODE overwrites it.

## Timing
- Reset values (after a clock edge with `rst_n`=0):
  - state = IDLE, `ready`=1, `display_bits`=72'h0, `update`=0
  - capture registers = 0
- Accept edge is E0. `ready` is 0 from the cycle after E0.
- Decimal: CONVERT occupies E1..E32 and ENCODE is E33. New `display_bits` and `update`=1 are visible after E33, for one cycle, with `ready`=1 in that same cycle.
- Hex or overflow: ENCODE at E1; outputs visible after E1.
- Throughput: a new accept is possible in the cycle `update` is high.
- Reset asserted mid-CONVERT or mid-ENCODE:
  - aborts the conversion and clears `display_bits` to 0;
  - no `update` pulse;
  - `ready`=1 after the reset edge.
- `ready` is a state decode with no combinational path from `value_valid`.

## Configuration
- `DISPLAY_FMT_LZB_EN` defined: leading-zero blanking is enabled.
  - Decimal: zero digits above the most significant non-zero digit are blank; digit 0 is always shown.
  - Hex: digits 7..1 are blanked the same way.
  - Overflow dashes are unaffected.
- Not defined: all digits are shown, including leading '0'; hex digit 8 remains blank.
- Latency is identical in both builds.

## Test plan
- Reset, then idle:
  - `display_bits`=0, `ready`=1, `update`=0.
- Decimal 1234, `dp_mask`=0, without the macro:
  - bytes 0..3 = 66,4F,5B,06; bytes 4..8 = 3F;
  - `update` one cycle after E33.
  - With the macro: bytes 4..8 = 00.
- Hex 0xDEADBEEF, `dp_mask`=9'h001:
  - bytes 0..8 = F1,79,79,7C,5E,77,79,5E,00;
  - `update` after E1.
- Decimal 1_000_000_000:
  - all bytes = 40, `update` after E1.
  - Decimal 0 with the macro: byte 0 = 3F, others = 00.
- Start decimal 42, then toggle `value`/`value_valid` during CONVERT:
  - the result still shows 42;
  - no second accept until `update`.
- Assert `rst_n`=0 at E10 of a conversion:
  - `display_bits`=0, no `update`, `ready`=1.
  - A subsequent hex accept of 0x5 yields byte 0 = 6D.
